// File: rtl/prbs_pattern_gen.sv
// Pattern/PRBS stimulus generator: emits a captured preamble n times, then a
// PRBS7/15/23/31 stream seeded from it. Define PRBS_ERR_INJ_EN to add err_inj.
module prbs_pattern_gen #(
    parameter int PAT_W = 32,
    parameter int OUT_W = 8,
    parameter int N_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data_valid,
    input  logic [PAT_W-1:0] in,
    input  logic [N_W-1:0]   n,
    input  logic [1:0]       poly_sel,
    input  logic             restart,
`ifdef PRBS_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic [OUT_W-1:0] PRBS_OUT,
    output logic             out_valid,
    output logic [1:0]       phase
);

    // Handshake: a word is produced on every edge that samples data_valid=1
    // with restart=0; out_valid marks it for exactly that following cycle.
    localparam int BEATS = PAT_W / OUT_W;
    localparam int BW    = $clog2(BEATS + 1);

    localparam logic [1:0] PH_IDLE    = 2'd0;
    localparam logic [1:0] PH_PATTERN = 2'd1;
    localparam logic [1:0] PH_PRBS    = 2'd2;

    logic [PAT_W-1:0] pat_q;
    logic [N_W-1:0]   n_q;
    logic [1:0]       poly_q;
    logic [BW-1:0]    beat_cnt;
    logic [N_W-1:0]   rep_cnt;
    logic [30:0]      lfsr;

    logic             start;
    logic             go_prbs;
    logic [PAT_W-1:0] pat_src;
    logic [1:0]       poly_src;
    logic [BW-1:0]    beat_idx;
    logic [BW-1:0]    beat_nxt;
    logic [N_W-1:0]   rep_src;
    logic [OUT_W-1:0] beat_word;
    logic [PAT_W-1:0] pat_shift;
    int               shamt;
    logic [30:0]      seed_src;
    logic [30:0]      seed_mask;
    logic [30:0]      seed;
    logic [30:0]      lfsr_src;
    logic [30:0]      prbs_next;
    logic [OUT_W-1:0] prbs_word;
    logic [OUT_W-1:0] word_out;

    assign start    = (phase == PH_IDLE) && data_valid && !restart;
    assign pat_src  = start ? in : pat_q;
    assign poly_src = start ? poly_sel : poly_q;
    assign beat_idx = start ? '0 : beat_cnt;
    assign rep_src  = start ? '0 : rep_cnt;
    assign go_prbs  = (start && (n == '0)) || (phase == PH_PRBS) ||
                      ((phase == PH_PATTERN) && (rep_cnt == n_q));

    // Beat k is the k-th OUT_W slice counted from the pattern MSB.
    always_comb begin
        shamt     = (BEATS - 1 - int'(beat_idx)) * OUT_W;
        pat_shift = pat_src >> shamt;
        beat_word = pat_shift[OUT_W-1:0];
        beat_nxt  = beat_idx + BW'(1);
    end

    always_comb begin
        seed_src = '0;
        for (int i = 0; i < 31; i++) begin
            if (i < PAT_W) seed_src[i] = in[i % PAT_W];
        end
        case (poly_sel)
            2'd0:    seed_mask = 31'h0000_007F;
            2'd1:    seed_mask = 31'h0000_7FFF;
            2'd2:    seed_mask = 31'h007F_FFFF;
            default: seed_mask = 31'h7FFF_FFFF;
        endcase
        seed = seed_src & seed_mask;
        if (seed == '0) seed = 31'h7FFF_FFFF;
    end

    assign lfsr_src = start ? seed : lfsr;

    // Bits above L-1 carry stale history but are never tapped, so the whole
    // 31-bit register can shift uniformly for every polynomial.
    always_comb begin
        logic [30:0] s;
        logic [4:0]  ta;
        logic [4:0]  tb;
        logic        fb;
        s  = lfsr_src;
        fb = 1'b0;
        prbs_word = '0;
        case (poly_src)
            2'd0:    begin ta = 5'd6;  tb = 5'd5;  end
            2'd1:    begin ta = 5'd14; tb = 5'd13; end
            2'd2:    begin ta = 5'd22; tb = 5'd17; end
            default: begin ta = 5'd30; tb = 5'd27; end
        endcase
        for (int i = 0; i < OUT_W; i++) begin
            fb = s[ta] ^ s[tb];
            prbs_word[OUT_W-1-i] = fb;
            s = {s[29:0], fb};
        end
        prbs_next = s;
    end

    always_comb begin
        word_out = prbs_word;
`ifdef PRBS_ERR_INJ_EN
        word_out[0] = prbs_word[0] ^ err_inj;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            PRBS_OUT  <= '0;
            out_valid <= 1'b0;
            phase     <= PH_IDLE;
            pat_q     <= '0;
            n_q       <= '0;
            poly_q    <= '0;
            beat_cnt  <= '0;
            rep_cnt   <= '0;
            lfsr      <= 31'h7FFF_FFFF;
        end else if (restart) begin
            PRBS_OUT  <= '0;
            out_valid <= 1'b0;
            phase     <= PH_IDLE;
            beat_cnt  <= '0;
            rep_cnt   <= '0;
            lfsr      <= 31'h7FFF_FFFF;
        end else if (data_valid) begin
            out_valid <= 1'b1;
            if (start) begin
                pat_q  <= in;
                n_q    <= n;
                poly_q <= poly_sel;
            end
            if (go_prbs) begin
                PRBS_OUT <= word_out;
                phase    <= PH_PRBS;
                lfsr     <= prbs_next;
            end else begin
                PRBS_OUT <= beat_word;
                phase    <= PH_PATTERN;
                lfsr     <= lfsr_src;
                if (beat_nxt == BW'(BEATS)) begin
                    beat_cnt <= '0;
                    rep_cnt  <= rep_src + N_W'(1);
                end else begin
                    beat_cnt <= beat_nxt;
                    rep_cnt  <= rep_src;
                end
            end
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Bench for prbs_pattern_gen: two instances (OUT_W=8 and OUT_W=1) on shared
// stimulus, checked against a bit-sequence recurrence model.
module tb_prbs_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       data_valid;
    logic       restart;
    logic       err_inj;
    logic [31:0] in_w;
    logic [7:0]  n_w;
    logic [1:0]  poly_w;
    logic [7:0]  o8;
    logic        ov8;
    logic [1:0]  ph8;
    logic [0:0]  o1;
    logic        ov1;
    logic [1:0]  ph1;

`ifdef PRBS_ERR_INJ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    prbs_pattern_gen #(.PAT_W(32), .OUT_W(8), .N_W(8)) dut8 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .in(in_w), .n(n_w),
        .poly_sel(poly_w), .restart(restart),
`ifdef PRBS_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .PRBS_OUT(o8), .out_valid(ov8), .phase(ph8)
    );

    prbs_pattern_gen #(.PAT_W(32), .OUT_W(1), .N_W(8)) dut1 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .in(in_w), .n(n_w),
        .poly_sel(poly_w), .restart(restart),
`ifdef PRBS_ERR_INJ_EN
        .err_inj(err_inj),
`endif
        .PRBS_OUT(o1), .out_valid(ov1), .phase(ph1)
    );

    int checks = 0;
    int errors = 0;

    logic       bits_q[$];
    logic [7:0] exp_q8[$];
    logic [0:0] exp_q1[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected bit stream: the pattern MSB-first nrep times, then the PRBS
    // written as the recurrence b[t] = b[t-A] ^ b[t-B] over the seed history.
    task automatic build_model(input logic [31:0] pin, input int nrep, input int poly,
                               input int prbs_bits);
        int L, ta, tb;
        logic [31:0] mask, seed;
        logic hist[$];
        logic [7:0] w;
        case (poly)
            0:       begin L = 7;  ta = 7;  tb = 6;  end
            1:       begin L = 15; ta = 15; tb = 14; end
            2:       begin L = 23; ta = 23; tb = 18; end
            default: begin L = 31; ta = 31; tb = 28; end
        endcase
        mask = (32'h1 << L) - 32'h1;
        seed = pin & mask;
        if (seed == 32'h0) seed = mask;
        bits_q.delete();
        exp_q8.delete();
        exp_q1.delete();
        for (int r = 0; r < nrep; r++)
            for (int k = 31; k >= 0; k--) bits_q.push_back(pin[k]);
        for (int k = L - 1; k >= 0; k--) hist.push_back(seed[k]);
        for (int t = 0; t < prbs_bits; t++) begin
            hist.push_back(hist[hist.size() - ta] ^ hist[hist.size() - tb]);
            bits_q.push_back(hist[hist.size() - 1]);
        end
        for (int k = 0; k < bits_q.size(); k++) exp_q1.push_back(bits_q[k]);
        for (int k = 0; k + 8 <= bits_q.size(); k += 8) begin
            w = '0;
            for (int j = 0; j < 8; j++) w = {w[6:0], bits_q[k + j]};
            exp_q8.push_back(w);
        end
    endtask

    task automatic go_idle(input logic dv);
        @(negedge clk);
        restart    = 1'b1;
        data_valid = dv;
        err_inj    = 1'b0;
        @(posedge clk); #1;
        check("restart_ov8", ov8, 0);
        check("restart_o8", o8, 0);
        check("restart_ph8", ph8, 0);
        check("restart_ov1", ov1, 0);
        check("restart_ph1", ph1, 0);
        @(negedge clk);
        restart    = 1'b0;
        data_valid = 1'b0;
    endtask

    task automatic run_seq(input logic [31:0] pin, input int nrep, input int poly,
                           input int cycles, input bit gapped,
                           output logic [7:0] f0, output logic [7:0] f1);
        int i8, i1, np8, np1;
        logic dv, inj;
        logic [7:0] last8;
        logic [0:0] last1;
        logic [1:0] lph8, lph1;
        build_model(pin, nrep, poly, 8 * cycles + 8);
        np8 = nrep * 4;
        np1 = nrep * 32;
        i8 = 0; i1 = 0; last8 = '0; last1 = '0; lph8 = 2'd0; lph1 = 2'd0;
        f0 = '0; f1 = '0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            restart = 1'b0;
            if (c == 0) begin
                in_w = pin; n_w = 8'(nrep); poly_w = 2'(poly);
                data_valid = 1'b1;
            end else begin
                in_w = $urandom; n_w = 8'($urandom); poly_w = 2'($urandom);
                data_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            err_inj = ERR_EN ? ($urandom_range(0, 7) == 0) : 1'b0;
            dv  = data_valid;
            inj = err_inj;
            @(posedge clk); #1;
            check("valid8", ov8, dv);
            check("valid1", ov1, dv);
            if (dv) begin
                lph8  = (i8 < np8) ? 2'd1 : 2'd2;
                last8 = exp_q8[i8];
                if (inj && lph8 == 2'd2) last8[0] = ~last8[0];
                if (i8 == np8) f0 = o8;
                if (i8 == np8 + 1) f1 = o8;
                i8++;
                lph1  = (i1 < np1) ? 2'd1 : 2'd2;
                last1 = exp_q1[i1];
                if (inj && lph1 == 2'd2) last1[0] = ~last1[0];
                i1++;
            end
            check("word8", o8, last8);
            check("phase8", ph8, lph8);
            check("word1", o1, last1);
            check("phase1", ph1, lph1);
        end
    endtask

    task automatic run_period();
        logic [31:0] pin;
        pin = $urandom;
        build_model(pin, 0, 0, 127);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c == 0) begin in_w = pin; n_w = 8'd0; poly_w = 2'd0; end
            data_valid = 1'b1;
            err_inj    = 1'b0;
            @(posedge clk); #1;
            check("period_word1", o1, exp_q1[c % 127]);
        end
    endtask

    logic [7:0] f0, f1;

    initial begin
        rst = 1'b1; data_valid = 1'b0; restart = 1'b0; err_inj = 1'b0;
        in_w = '0; n_w = '0; poly_w = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_o8", o8, 0);
        check("reset_ov8", ov8, 0);
        check("reset_ph8", ph8, 0);
        check("reset_o1", o1, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_hold_ph8", ph8, 0);
        check("idle_hold_ov8", ov8, 0);

        // Preamble then PRBS7 seeded with 0x2B.
        run_seq(32'hABCDEFAB, 3, 0, 20, 1'b0, f0, f1);

        // Skip preamble, all-ones seed and zero-seed substitution.
        go_idle(1'b0);
        run_seq(32'hFFFFFFFF, 0, 0, 6, 1'b0, f0, f1);
        check("skip_ones_w0", f0, 8'h02);
        check("skip_ones_w1", f1, 8'h0C);
        go_idle(1'b1);
        run_seq(32'h00000000, 0, 0, 6, 1'b0, f0, f1);
        check("skip_zero_w0", f0, 8'h02);
        check("skip_zero_w1", f1, 8'h0C);

        // Gapped data_valid across PATTERN and PRBS.
        for (int t = 0; t < 3; t++) begin
            go_idle(1'($urandom));
            run_seq($urandom, $urandom_range(1, 3), $urandom_range(0, 3), 60, 1'b1, f0, f1);
        end

        // Asynchronous reset in PRBS.
        go_idle(1'b0);
        run_seq($urandom, 0, 1, 10, 1'b0, f0, f1);
        @(negedge clk);
        data_valid = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("async_rst_o8", o8, 0);
        check("async_rst_ov8", ov8, 0);
        check("async_rst_ph8", ph8, 0);
        check("async_rst_ph1", ph1, 0);
        @(negedge clk);
        rst = 1'b0;
        data_valid = 1'b0;

        // Restart during PATTERN with data_valid high, then a fresh n=1 preamble.
        run_seq(32'h12345678, 2, 0, 3, 1'b0, f0, f1);
        go_idle(1'b1);
        run_seq($urandom, 1, $urandom_range(0, 3), 12, 1'b0, f0, f1);

        // Each polynomial, 200 words.
        for (int p = 1; p <= 3; p++) begin
            go_idle(1'b0);
            run_seq($urandom, 0, p, 200, 1'b0, f0, f1);
        end

        // PRBS7 single-bit stream repeats every 127 words.
        go_idle(1'b0);
        run_period();

        go_idle(1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Parametrised pattern/PRBS stimulus generator, the next generation of the team's fixed 32-bit/8-bit PRBS block. After a start it emits a programmable preamble pattern `n` times. It then switches to a run-time-selectable PRBS sequence (PRBS7/15/23/31) seeded from the same pattern. It feeds link and DAC datapath benches and the on-chip loopback test path. Output word width and pattern width are parameters.

## Interface
- `PAT_W`, 32: preamble pattern width; must be a multiple of `OUT_W`.
- `OUT_W`, 8: output word width; 1..31.
- `N_W`, 8: width of the repetition count.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `data_valid`  in  1  enable; high = produce one word this cycle; low = hold all state.
- `in`  in  `PAT_W`  preamble pattern and LFSR seed source; sampled at start.
- `n`  in  `N_W`  number of preamble repetitions; sampled at start.
- `poly_sel`  in  2  0=PRBS7 (x^7+x^6+1), 1=PRBS15 (x^15+x^14+1), 2=PRBS23 (x^23+x^18+1), 3=PRBS31 (x^31+x^28+1); sampled at start.
- `restart`  in  1  synchronous return to IDLE; has priority over `data_valid`.
- `PRBS_OUT`  out  `OUT_W`  output word, registered.
- `out_valid`  out  1  high for one cycle per produced word.
- `phase`  out  2  0=IDLE, 1=PATTERN, 2=PRBS.

## Operation
- **Reset values:** `PRBS_OUT`=0, `out_valid`=0, `phase`=0. Counters are 0 and the LFSR is all-ones.
- **IDLE:** stays here while `data_valid`=0.
- **Start:** the first edge with `data_valid`=1 in IDLE.
  - Captures `in`, `n` and `poly_sel`.
  - LFSR length L is 7, 15, 23 or 31. Seed = `in[L-1:0]`; if that is zero, the seed is all-ones.
  - If `n`>0, enters PATTERN and outputs beat 0. If `n`=0, enters PRBS and outputs PRBS word 0.
- **PATTERN:**
  - BEATS = `PAT_W`/`OUT_W`. Beats are emitted MSB-first; beat k = captured `in[PAT_W-1-k*OUT_W -: OUT_W]`.
  - A beat counter wraps at BEATS and increments a repetition counter.
  - After `n`×BEATS words the next valid cycle outputs PRBS word 0 and `phase`=2.
- **PRBS:**
  - Fibonacci LFSR. Per step: fb = s[tapA-1]^s[tapB-1], s <= {s[L-2:0], fb}. Taps are (7,6), (15,14), (23,18) or (31,28).
  - Each word = `OUT_W` successive fb bits. The first generated bit goes to the MSB.
  - The LFSR advances exactly `OUT_W` steps per valid word.
  - Runs until `restart` or `rst`.
- **`data_valid`=0 in PATTERN/PRBS:** `out_valid`=0. `PRBS_OUT`, counters, LFSR and `phase` hold. Resumes seamlessly on the next valid cycle.
- **`restart`=1:** next edge → IDLE; `out_valid`=0 and `PRBS_OUT`=0. A start needs a later `data_valid` cycle with `restart`=0.
- **Input changes:** changes to `in`, `n` or `poly_sel` after start are ignored until the next start.

## Timing
- Latency is 1 cycle: the word is valid after the edge that samples `data_valid`=1.
- Full throughput: one word per clock while `data_valid`=1.
- PATTERN→PRBS transition has no bubble.
- `rst` asserted mid-operation clears outputs immediately (asynchronous). Deassertion is taken at a clock edge; the first start can occur at the next edge.
- `restart` and `data_valid` in the same cycle: `restart` wins, and no word is produced.

## Configuration
- `PRBS_ERR_INJ_EN` defined:
  - Adds port `err_inj` (in, 1).
  - On a valid PRBS-phase word with `err_inj`=1, the word's LSB is inverted.
  - The LFSR sequence is unaffected, so exactly one bit error is created.
  - `err_inj` is ignored in PATTERN.
- `PRBS_ERR_INJ_EN` undefined: the port and its logic are absent, and output is the pure sequence.

## Test plan
- **Preamble then PRBS:** `OUT_W`=8, `in`=0xABCDEFAB, `n`=3, `poly_sel`=0, `data_valid` held high → 12 words AB CD EF AB repeated ×3. The 13th word has `phase`=2 and matches a bit-accurate PRBS7 model seeded with 0x2B.
- **Skip preamble:** `in`=0xFFFFFFFF, `n`=0, PRBS7 → first words 0x02, 0x0C, `phase`=2 on the start edge. With `in`=0 (zero-seed substitution) → identical 0x02, 0x0C.
- **Gapped `data_valid`:** toggle `data_valid` 1,0,0,1 during PATTERN and PRBS → `out_valid` follows with 1-cycle latency. The gapless word stream equals the ungapped run.
- **Reset/restart mid-run:**
  - `rst` pulse in PRBS → outputs 0 immediately.
  - `restart` in PATTERN together with `data_valid`=1 → IDLE, no word produced. A new start with `n`=1 re-emits the preamble from beat 0.
- **All polynomials:** `poly_sel`=1,2,3, `OUT_W`=8 and `OUT_W`=1, 200 words each → match the model. For PRBS7 with `OUT_W`=1, the sequence repeats every 127 words.
- **Error injection (`PRBS_ERR_INJ_EN`):** `err_inj`=1 for one PRBS word → only that word differs from the model, in bit 0. An `err_inj` pulse during PATTERN has no effect.
